// File: rtl/nn4h_pkg.sv
// Shared types and Q4.4 constants for the hidden-layer input feeder.
package nn4h_pkg;

    localparam int unsigned DATA_W = 8;
    localparam int unsigned FRAC   = 4;

    localparam logic signed [DATA_W-1:0] Q_MAX = 8'sh7F;
    localparam logic signed [DATA_W-1:0] Q_MIN = 8'sh80;

    typedef enum logic [1:0] {
        FILL,
        IDLE,
        REQ,
        RELEASE
    } feeder_state_t;

endpackage

// File: rtl/layer_input_feeder_if.sv
// Host write port and layer-side req/ack/read port of the input feeder.
// The slave modport is the feeder itself; the master modport is its environment.
interface layer_input_feeder_if #(
    parameter int unsigned IN_W = 16,
    parameter int unsigned AW   = 1
);
    import nn4h_pkg::*;

    logic                     in_valid;
    logic signed [IN_W-1:0]   in_data;
    logic                     in_ready;
    logic                     fill;
    logic                     req;
    logic                     rd_en;
    logic [AW-1:0]            rd_addr;
    logic signed [DATA_W-1:0] rd_data;
    logic                     ack_layer;
    logic [15:0]              frames_done;

    modport master (
        output in_valid, in_data, rd_en, rd_addr, ack_layer,
        input  in_ready, fill, req, rd_data, frames_done
    );

    modport slave (
        input  in_valid, in_data, rd_en, rd_addr, ack_layer,
        output in_ready, fill, req, rd_data, frames_done
    );

endinterface

// File: rtl/feeder_q44_conv.sv
// Host sample to Q4.4 conversion; both formats share the fractional bits.
// Define FEEDER_SAT_EN to saturate out-of-range samples instead of wrapping.
module feeder_q44_conv
    import nn4h_pkg::*;
#(
    parameter int unsigned IN_W = 16
) (
    input  logic signed [IN_W-1:0]   din,
    output logic signed [DATA_W-1:0] dout
);

`ifdef FEEDER_SAT_EN
    logic in_range;

    always_comb begin
        // In range only when every bit above the Q4.4 sign matches it.
        in_range = (din[IN_W-1:DATA_W-1] == {(IN_W - DATA_W + 1){din[IN_W-1]}});
        if (in_range) begin
            dout = din[DATA_W-1:0];
        end else if (din[IN_W-1]) begin
            dout = Q_MIN;
        end else begin
            dout = Q_MAX;
        end
    end
`else
    logic unused_hi;

    assign unused_hi = ^din[IN_W-1:DATA_W];
    assign dout      = din[DATA_W-1:0];
`endif

endmodule

// File: rtl/layer_input_feeder.sv
// Ping-pong vector buffer feeding the hidden layer: weight-fill strobe after reset,
// then one req/ack transaction per full bank while the host fills the other bank.
module layer_input_feeder
    import nn4h_pkg::*;
#(
    parameter int unsigned DEPTH       = 2,
    parameter int unsigned AW          = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    parameter int unsigned IN_W        = 16,
    parameter int unsigned FILL_CYCLES = 2
) (
    input logic                 clk,
    input logic                 rst,
    layer_input_feeder_if.slave bus
);

    localparam int unsigned CW = $clog2(FILL_CYCLES + 1);

    feeder_state_t            state_q, state_d;
    logic [CW-1:0]            fill_cnt_q;
    logic                     ack_q;
    logic                     ack_rise;
    logic [1:0]               full_q, full_d;
    logic                     wr_bank_q, rd_bank_q;
    logic [AW-1:0]            wr_ptr_q;
    logic [15:0]              frames_done_q;
    logic signed [DATA_W-1:0] mem_q [2][DEPTH];
    logic signed [DATA_W-1:0] conv_data;
    logic                     wr_en, wr_last, release_en;

    feeder_q44_conv #(
        .IN_W (IN_W)
    ) u_conv (
        .din  (bus.in_data),
        .dout (conv_data)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            FILL:    if (fill_cnt_q == CW'(FILL_CYCLES)) state_d = IDLE;
            IDLE:    if (full_q[rd_bank_q]) state_d = REQ;
            REQ:     if (ack_rise) state_d = RELEASE;
            RELEASE: state_d = IDLE;
            default: state_d = FILL;
        endcase
    end

    // fill_cnt_q is zero while reset is held, which keeps fill low until release.
    always_comb begin
        bus.fill     = (state_q == FILL) && (fill_cnt_q != '0);
        bus.req      = (state_q == REQ);
        bus.in_ready = (state_q != FILL) && !full_q[wr_bank_q];
        release_en   = (state_q == RELEASE);
    end

    assign ack_rise = bus.ack_layer && !ack_q;
    assign wr_en    = bus.in_valid && bus.in_ready;
    assign wr_last  = (wr_ptr_q == AW'(DEPTH - 1));

    // The released bank is full, so the write side can never target it this cycle.
    always_comb begin
        full_d = full_q;
        if (release_en) full_d[rd_bank_q] = 1'b0;
        if (wr_en && wr_last) full_d[wr_bank_q] = 1'b1;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill_cnt_q    <= '0;
            ack_q         <= 1'b1;
            full_q        <= '0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            wr_ptr_q      <= '0;
            frames_done_q <= '0;
        end else begin
            ack_q  <= bus.ack_layer;
            full_q <= full_d;
            if (state_q == FILL && fill_cnt_q != CW'(FILL_CYCLES)) begin
                fill_cnt_q <= fill_cnt_q + CW'(1);
            end
            if (wr_en) begin
                wr_ptr_q <= wr_last ? '0 : wr_ptr_q + AW'(1);
                if (wr_last) wr_bank_q <= ~wr_bank_q;
            end
            if (release_en) begin
                rd_bank_q     <= ~rd_bank_q;
                frames_done_q <= frames_done_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_bank_q][wr_ptr_q] <= conv_data;
    end

    always_comb begin
        bus.rd_data = '0;
        if (bus.rd_en && (32'(bus.rd_addr) < DEPTH)) begin
            bus.rd_data = mem_q[rd_bank_q][bus.rd_addr];
        end
    end

    assign bus.frames_done = frames_done_q;

endmodule

// File: tb/tb_layer_input_feeder.sv
// Self-checking bench for layer_input_feeder: converted host samples are queued on accept
// and compared against what the layer reads back once req is raised.
module tb_layer_input_feeder;
    import nn4h_pkg::*;

    localparam int unsigned DEPTH = 2;
    localparam int          BOUND = 50;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail = 0;
    int   exp_frames = 0;
    logic signed [DATA_W-1:0] sb_q [$];

    layer_input_feeder_if #(.IN_W(16), .AW(1)) bus ();

    layer_input_feeder #(
        .DEPTH       (DEPTH),
        .AW          (1),
        .IN_W        (16),
        .FILL_CYCLES (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    function automatic logic signed [DATA_W-1:0] model_conv(input logic signed [15:0] v);
        logic [15:0] t;
        t = v;
`ifdef FEEDER_SAT_EN
        if (v > 16'sd127) return 8'sh7F;
        if (v < -16'sd128) return 8'sh80;
`endif
        return t[7:0];
    endfunction

    // Observes the fill strobe after reset release; called on the release negedge.
    task automatic measure_fill(output int fill_len, output int overlap);
        fill_len = 0;
        overlap  = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            if (bus.fill) fill_len++;
            if (bus.fill && bus.in_ready) overlap++;
        end
    endtask

    // Called on a negedge; returns on the negedge after the accepting posedge.
    task automatic send_sample(input logic signed [15:0] v);
        bit accepted = 0;
        int waited = 0;
        bus.in_valid = 1'b1;
        bus.in_data  = v;
        while (!accepted && waited < BOUND) begin
            if (bus.in_ready) accepted = 1;
            @(negedge clk);
            waited++;
        end
        bus.in_valid = 1'b0;
        n_checks++;
        if (!accepted) begin
            n_fail++;
            $display("FAIL send_sample %h: in_ready=%0b after %0d cycles, required 1",
                     v, bus.in_ready, waited);
        end else begin
            sb_q.push_back(model_conv(v));
        end
    endtask

    task automatic read_vector(input string tag);
        int waited = 0;
        logic signed [DATA_W-1:0] exp;
        while (!bus.req && waited < BOUND) begin
            @(negedge clk);
            waited++;
        end
        n_checks++;
        if (!bus.req) begin
            n_fail++;
            $display("FAIL %s req_wait: req=%0b after %0d cycles, required 1", tag, bus.req, waited);
        end
        for (int a = 0; a < DEPTH; a++) begin
            bus.rd_en   = 1'b1;
            bus.rd_addr = 1'(a);
            #1;
            n_checks++;
            if (sb_q.size() == 0) begin
                n_fail++;
                $display("FAIL %s rd_data[%0d]: got %h with empty scoreboard", tag, a, bus.rd_data);
            end else begin
                exp = sb_q.pop_front();
                if (bus.rd_data !== exp) begin
                    n_fail++;
                    $display("FAIL %s rd_data[%0d]: got %h, required %h", tag, a, bus.rd_data, exp);
                end
            end
        end
        bus.rd_en = 1'b0;
    endtask

    // Gives ack one low cycle, raises it, and follows the RELEASE cycle.
    task automatic release_vector(input string tag, input bit hold);
        bus.ack_layer = 1'b0;
        @(negedge clk);
        bus.ack_layer = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL %s req_drop: req=%0b, required 0", tag, bus.req);
        end
        @(negedge clk);
        exp_frames++;
        n_checks++;
        if (bus.frames_done !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL %s frames_done: got %0d, required %0d", tag, bus.frames_done, exp_frames);
        end
        if (!hold) bus.ack_layer = 1'b0;
    endtask

    task automatic test_reset();
        int fl, ov;
        @(negedge clk);
        repeat (2) @(negedge clk);
        n_checks++;
        if ({bus.fill, bus.req, bus.in_ready} !== 3'b000 || bus.frames_done !== 16'd0) begin
            n_fail++;
            $display("FAIL reset_values: fill/req/in_ready=%b frames=%0d, required 000 and 0",
                     {bus.fill, bus.req, bus.in_ready}, bus.frames_done);
        end
        rst = 1'b1;
        measure_fill(fl, ov);
        n_checks++;
        if (fl !== 2) begin
            n_fail++;
            $display("FAIL reset_fill_len: fill high %0d cycles, required 2", fl);
        end
        n_checks++;
        if (ov !== 0) begin
            n_fail++;
            $display("FAIL reset_ready_in_fill: in_ready high %0d fill cycles, required 0", ov);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_after_fill: in_ready=%0b req=%0b, required 1 and 0",
                     bus.in_ready, bus.req);
        end
    endtask

    task automatic test_basic_vector();
        send_sample(16'sh0010);
        send_sample(16'shFFF0);
        n_checks++;
        if (bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL basic_req_early: req=%0b on accept cycle, required 0", bus.req);
        end
        @(negedge clk);
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_req_rise: req=%0b one cycle after accept, required 1", bus.req);
        end
        bus.rd_en   = 1'b0;
        bus.rd_addr = 1'b0;
        #1;
        n_checks++;
        if (bus.rd_data !== 8'sh00) begin
            n_fail++;
            $display("FAIL basic_rd_idle: rd_data=%h with rd_en=0, required 00", bus.rd_data);
        end
        read_vector("basic");
        release_vector("basic", 1'b0);
    endtask

    task automatic test_back_pressure();
        int ready_cycles = 0;
        send_sample(16'sh0030);
        send_sample(16'sh0040);
        send_sample(16'sh0050);
        send_sample(16'sh0060);
        n_checks++;
        if (bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_ready_drop: in_ready=%0b with both banks full, required 0",
                     bus.in_ready);
        end
        bus.in_valid = 1'b1;
        bus.in_data  = 16'sh0070;
        repeat (4) begin
            @(negedge clk);
            if (bus.in_ready) ready_cycles++;
        end
        n_checks++;
        if (ready_cycles !== 0) begin
            n_fail++;
            $display("FAIL bp_stall: in_ready high %0d cycles, required 0", ready_cycles);
        end
        read_vector("bp_a");
        bus.ack_layer = 1'b1;
        @(negedge clk);
        n_checks++;
        if (bus.req !== 1'b0 || bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_release: req=%0b in_ready=%0b, required 0 and 0", bus.req, bus.in_ready);
        end
        @(negedge clk);
        exp_frames++;
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.req !== 1'b0 || bus.frames_done !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL bp_after_release: in_ready=%0b req=%0b frames=%0d, required 1 0 %0d",
                     bus.in_ready, bus.req, bus.frames_done, exp_frames);
        end
        @(negedge clk);
        bus.in_valid = 1'b0;
        sb_q.push_back(model_conv(16'sh0070));
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_req_again: req=%0b for second bank, required 1", bus.req);
        end
        bus.ack_layer = 1'b0;
        read_vector("bp_b");
        release_vector("bp_b", 1'b0);
    endtask

    task automatic test_conversion();
        send_sample(16'sh0200);
        read_vector("conv_a");
        release_vector("conv_a", 1'b0);
        send_sample(16'shFD00);
        send_sample(16'sh0123);
        read_vector("conv_b");
        release_vector("conv_b", 1'b0);
        send_sample(16'shFF80);
        send_sample(16'sh007F);
        read_vector("conv_c");
        release_vector("conv_c", 1'b0);
    endtask

    task automatic test_ack_held();
        int low_cycles = 0;
        send_sample(16'sh0011);
        send_sample(16'sh0022);
        read_vector("held_a");
        release_vector("held_a", 1'b1);
        send_sample(16'sh0033);
        send_sample(16'sh0044);
        read_vector("held_b");
        repeat (4) begin
            @(negedge clk);
            if (!bus.req) low_cycles++;
        end
        n_checks++;
        if (low_cycles !== 0 || bus.frames_done !== 16'(exp_frames)) begin
            n_fail++;
            $display("FAIL held_no_release: req low %0d cycles frames=%0d, required 0 and %0d",
                     low_cycles, bus.frames_done, exp_frames);
        end
        release_vector("held_b", 1'b0);
    endtask

    task automatic test_reset_mid();
        int fl, ov;
        send_sample(16'sh0055);
        send_sample(16'sh0066);
        send_sample(16'sh0077);
        n_checks++;
        if (bus.req !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_pre_req: req=%0b before reset, required 1", bus.req);
        end
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.req, bus.fill, bus.in_ready} !== 3'b000 || bus.frames_done !== 16'd0) begin
            n_fail++;
            $display("FAIL mid_reset_values: req/fill/in_ready=%b frames=%0d, required 000 and 0",
                     {bus.req, bus.fill, bus.in_ready}, bus.frames_done);
        end
        sb_q.delete();
        exp_frames = 0;
        @(negedge clk);
        rst = 1'b1;
        measure_fill(fl, ov);
        n_checks++;
        if (fl !== 2 || ov !== 0) begin
            n_fail++;
            $display("FAIL mid_fill: fill high %0d cycles overlap %0d, required 2 and 0", fl, ov);
        end
        n_checks++;
        if (bus.in_ready !== 1'b1 || bus.req !== 1'b0) begin
            n_fail++;
            $display("FAIL mid_banks_empty: in_ready=%0b req=%0b, required 1 and 0",
                     bus.in_ready, bus.req);
        end
        send_sample(16'sh0018);
        send_sample(16'shFFE8);
        read_vector("mid_after");
        release_vector("mid_after", 1'b0);
    endtask

    initial begin
        rst           = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = '0;
        bus.rd_en     = 1'b0;
        bus.rd_addr   = '0;
        bus.ack_layer = 1'b0;
        test_reset();
        test_basic_vector();
        test_back_pressure();
        test_conversion();
        test_ack_held();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
